// File: rtl/alu_pkg.sv
// Shared state encoding, opcode values and datapath widths for the
// multiplier issue queue.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        CLEAR  = 3'd2,
        BUSY   = 3'd3,
        SETTLE = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int OPERA1_W = 32;
    localparam int OPERA2_W = 64;
    localparam int RESULT_W = 64;

endpackage

// File: rtl/op_fifo.sv
// Small synchronous request FIFO with full/empty flags; DEPTH must be a
// power of two so the pointers wrap naturally.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 99
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_issue_queue.sv
// Sequencer in front of the shift-add multiplier: queues requests, drives
// start/operands with legal timing and returns a tagged result or error.
module mul_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 2,
    parameter int TIMEOUT = 48
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [OPERA1_W-1:0] req_opera1,
    input  logic [OPERA2_W-1:0] req_opera2,
    input  logic                req_muordi,
    input  logic [TAG_W-1:0]    req_tag,
    output logic [OPERA1_W-1:0] mul_opera1,
    output logic [OPERA2_W-1:0] mul_opera2,
    output logic                mul_muordi,
    output logic                mul_start,
    output logic                mul_abort,
    input  logic [RESULT_W-1:0] mul_result,
    input  logic                mul_valid,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [RESULT_W-1:0] rsp_result,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                rsp_err,
    output logic [2:0]          dbg_state
);

    localparam int ENTRY_W = 1 + OPERA1_W + OPERA2_W + TAG_W;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t state;
    state_t state_next;

    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;

    logic                head_muordi;
    logic [OPERA1_W-1:0] head_opera1;
    logic [OPERA2_W-1:0] head_opera2;
    logic [TAG_W-1:0]    head_tag;

    logic [OPERA1_W-1:0] opera1_q;
    logic [OPERA2_W-1:0] opera2_q;
    logic [TAG_W-1:0]    tag_q;
    logic [RESULT_W-1:0] result_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                timeout_hit;

    // Both request and response sides transfer exactly on a clock edge where
    // valid and ready are high together; valid never depends on ready.
    assign fifo_push  = req_valid && req_ready;
    assign req_ready  = !fifo_full;
    assign push_entry = {req_muordi, req_opera1, req_opera2, req_tag};

    assign head_muordi = head_entry[ENTRY_W-1];
    assign head_opera1 = head_entry[ENTRY_W-2 -: OPERA1_W];
    assign head_opera2 = head_entry[TAG_W +: OPERA2_W];
    assign head_tag    = head_entry[TAG_W-1:0];

    op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = (head_muordi == OP_DIV) ? RESP : START;
                end
            end
            START: begin
                state_next = CLEAR;
            end
            CLEAR: begin
                // The previous operation's valid is still visible for a while.
                if (!mul_valid) begin
                    state_next = BUSY;
                end else if (cnt_inc == TIMEOUT_C) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            BUSY: begin
                if (mul_valid) begin
                    state_next = SETTLE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
            end
            SETTLE: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opera1_q <= '0;
            opera2_q <= '0;
            tag_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            if (state == START) begin
                cnt <= '0;
            end else if (state == CLEAR || state == BUSY) begin
                cnt <= cnt_inc;
            end

            if (fifo_pop) begin
                opera1_q <= head_opera1;
                opera2_q <= head_opera2;
                tag_q    <= head_tag;
                if (head_muordi == OP_DIV) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
            end

            // Result is only final one cycle after valid rises.
            if (state == SETTLE) begin
                result_q <= mul_result;
                err_q    <= 1'b0;
            end

            if (timeout_hit) begin
                result_q <= '0;
                err_q    <= 1'b1;
            end
        end
    end

    assign mul_opera1 = opera1_q;
    assign mul_opera2 = opera2_q;
    assign mul_muordi = OP_MUL;
    assign mul_start  = (state == START);
    assign mul_abort  = timeout_hit;

    assign rsp_valid  = (state == RESP);
    assign rsp_result = result_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;

    assign dbg_state  = state;

endmodule

// File: tb/tb_mul_issue_queue.sv
// Bench for mul_issue_queue: directed vector table, multi-cycle corner
// sequences and randomized traffic against a behavioural multiplier.
module tb_mul_issue_queue;

    localparam int TAG_W   = 2;
    localparam int TIMEOUT = 48;
    localparam int MUL_LAT = 33;
    localparam int SB_W    = 64 + TAG_W + 1;
    localparam logic [2:0] BUSY_S = 3'd3;

    logic              clock      = 1'b0;
    logic              reset      = 1'b0;
    logic              req_valid  = 1'b0;
    logic              req_ready;
    logic [31:0]       req_opera1 = '0;
    logic [63:0]       req_opera2 = '0;
    logic              req_muordi = 1'b0;
    logic [TAG_W-1:0]  req_tag    = '0;
    logic [31:0]       mul_opera1;
    logic [63:0]       mul_opera2;
    logic              mul_muordi;
    logic              mul_start;
    logic              mul_abort;
    logic [63:0]       mul_result;
    logic              mul_valid;
    logic              rsp_valid;
    logic              rsp_ready  = 1'b1;
    logic [63:0]       rsp_result;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;
    logic [2:0]        dbg_state;

    mul_issue_queue #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opera1 (req_opera1),
        .req_opera2 (req_opera2),
        .req_muordi (req_muordi),
        .req_tag    (req_tag),
        .mul_opera1 (mul_opera1),
        .mul_opera2 (mul_opera2),
        .mul_muordi (mul_muordi),
        .mul_start  (mul_start),
        .mul_abort  (mul_abort),
        .mul_result (mul_result),
        .mul_valid  (mul_valid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] product(input logic [31:0] a, input logic [63:0] b);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
    endfunction

    // ---------------- behavioural multiplier ----------------
    logic        running;
    logic        prev_valid;
    logic        stuck = 1'b0;
    int          since_start;
    logic [63:0] final_q;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            running     <= 1'b0;
            prev_valid  <= 1'b0;
            since_start <= 0;
            final_q     <= '0;
        end else if (mul_abort) begin
            running     <= 1'b0;
            prev_valid  <= 1'b0;
            since_start <= 0;
        end else if (mul_start) begin
            running     <= 1'b1;
            prev_valid  <= mul_valid;
            since_start <= 1;
            final_q     <= product(mul_opera1, mul_opera2);
        end else if (since_start < 1000) begin
            since_start <= since_start + 1;
        end
    end

    assign mul_valid  = !stuck && ((prev_valid && since_start <= 1) ||
                                   (running && since_start >= MUL_LAT));
    assign mul_result = (running && since_start == MUL_LAT) ? ~final_q : final_q;

    // ---------------- scoreboard / monitor ----------------
    logic [SB_W-1:0] exp_q[$];
    int          start_cnt = 0;
    int          abort_cnt = 0;
    int          start_cyc = 0;
    int          abort_cyc = 0;
    int          stab_err  = 0;
    int          rsp_seen  = 0;
    logic        in_op     = 1'b0;
    logic [31:0] cap1;
    logic [63:0] cap2;

    initial forever begin
        logic [SB_W-1:0] exp_v;
        @(negedge clock);
        if (!reset) begin
            in_op = 1'b0;
        end else begin
            if (mul_start) begin
                start_cnt++;
                start_cyc = cyc;
                cap1  = mul_opera1;
                cap2  = mul_opera2;
                in_op = 1'b1;
                if (mul_muordi !== 1'b0) stab_err++;
            end else if (in_op && (mul_opera1 !== cap1 || mul_opera2 !== cap2)) begin
                stab_err++;
            end
            if (mul_abort) begin
                abort_cnt++;
                abort_cyc = cyc;
            end
            if (rsp_valid) begin
                rsp_seen++;
                in_op = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 128'(exp_q.size() != 0), 128'(1'b1));
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check("rsp_scoreboard", 128'({rsp_err, rsp_tag, rsp_result}), 128'(exp_v));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic rand_rdy = 1'b0;
    initial forever begin
        @(posedge clock);
        #1;
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [63:0] b,
                            input logic d, input logic [TAG_W-1:0] t);
        logic acc;
        int   n;
        req_opera1 = a;
        req_opera2 = b;
        req_muordi = d;
        req_tag    = t;
        req_valid  = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clock);
            acc = req_ready;
            @(posedge clock);
            #1;
            n++;
        end
        req_valid = 1'b0;
        check("push_accept", 128'(acc), 128'(1'b1));
        if (acc) exp_q.push_back(d ? {1'b1, t, 64'd0} : {1'b0, t, product(a, b)});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            wait_cycles(1);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'(0));
        wait_cycles(2);
    endtask

    task automatic check_reset_vals(input string tag_s);
        check({tag_s, "_mul_opera1"}, 128'(mul_opera1), 128'(0));
        check({tag_s, "_mul_opera2"}, 128'(mul_opera2), 128'(0));
        check({tag_s, "_ctrl"}, 128'({mul_muordi, mul_start, mul_abort, rsp_valid, rsp_err}), 128'(0));
        check({tag_s, "_rsp_result"}, 128'(rsp_result), 128'(0));
        check({tag_s, "_rsp_tag"}, 128'(rsp_tag), 128'(0));
        check({tag_s, "_req_ready"}, 128'(req_ready), 128'(1'b1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0]      a;
        logic [63:0]      b;
        logic             d;
        logic [TAG_W-1:0] t;
        logic [63:0]      res;
        logic             err;
        int               lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int s0;
        int a0;
        int k;
        int n;
        logic [63:0] h_res;
        logic [TAG_W-1:0] h_tag;
        logic h_err;
        int hold_err;

        vecs[0] = '{32'd3,          64'd5,                     1'b0, 2'd1, 64'h0000_0000_0000_000F, 1'b0, 37};
        vecs[1] = '{32'hFFFF_FFF9,  64'd6,                     1'b0, 2'd3, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 37};
        vecs[2] = '{32'd9,          64'd4,                     1'b1, 2'd2, 64'h0,                   1'b1, 2};
        vecs[3] = '{32'd0,          64'h1234,                  1'b0, 2'd0, 64'h0,                   1'b0, 37};
        vecs[4] = '{32'h8000_0000,  64'd2,                     1'b0, 2'd1, 64'hFFFF_FFFF_0000_0000, 1'b0, 37};
        vecs[5] = '{32'h0001_0000,  64'h0000_0001_0000_0000,   1'b0, 2'd2, 64'h0001_0000_0000_0000, 1'b0, 37};
        vecs[6] = '{32'd1,          64'h8000_0000_0000_0000,   1'b0, 2'd3, 64'h8000_0000_0000_0000, 1'b0, 37};
        vecs[7] = '{32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF,   1'b1, 2'd0, 64'h0,                   1'b1, 2};

        // reset state
        wait_cycles(3);
        check_reset_vals("reset");
        check("reset_state", 128'(dbg_state), 128'(0));
        reset = 1'b1;
        wait_cycles(2);

        // table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            s0 = start_cnt;
            push_req(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].t);
            n = 1;
            while (rsp_valid !== 1'b1 && n < 100) begin
                wait_cycles(1);
                n++;
            end
            check($sformatf("v%0d_latency", i), 128'(n), 128'(vecs[i].lat));
            check($sformatf("v%0d_result", i), 128'(rsp_result), 128'(vecs[i].res));
            check($sformatf("v%0d_tag", i), 128'(rsp_tag), 128'(vecs[i].t));
            check($sformatf("v%0d_err", i), 128'(rsp_err), 128'(vecs[i].err));
            wait_cycles(2);
            check($sformatf("v%0d_starts", i), 128'(start_cnt - s0), 128'(vecs[i].d ? 0 : 1));
        end

        // back-to-back pushes while the first operation executes
        push_req(32'd10, 64'd20, 1'b0, 2'd0);
        wait_cycles(5);
        push_req(32'd11, 64'd21, 1'b0, 2'd1);
        push_req(32'd12, 64'd22, 1'b1, 2'd2);
        push_req(32'd13, 64'd23, 1'b0, 2'd3);
        check("ready_before_full", 128'(req_ready), 128'(1'b1));
        push_req(32'hFFFF_FFFE, 64'd24, 1'b0, 2'd0);
        check("ready_when_full", 128'(req_ready), 128'(1'b0));
        push_req(32'd15, 64'd25, 1'b0, 2'd1);
        drain();

        // response held under backpressure
        rsp_ready = 1'b0;
        push_req(32'd11, 64'd13, 1'b0, 2'd1);
        push_req(32'hFFFF_FFFD, 64'd2, 1'b0, 2'd2);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            wait_cycles(1);
            n++;
        end
        check("hold_rsp_seen", 128'(rsp_valid), 128'(1'b1));
        h_res = rsp_result;
        h_tag = rsp_tag;
        h_err = rsp_err;
        s0 = start_cnt;
        hold_err = 0;
        for (int i = 0; i < 20; i++) begin
            wait_cycles(1);
            if (rsp_valid !== 1'b1 || rsp_result !== h_res || rsp_tag !== h_tag || rsp_err !== h_err)
                hold_err++;
        end
        check("hold_result", 128'(h_res), 128'(64'd143));
        check("hold_stable", 128'(hold_err), 128'(0));
        check("hold_no_start", 128'(start_cnt - s0), 128'(0));
        rsp_ready = 1'b1;
        k = cyc;
        wait_cycles(3);
        check("issue_after_ack", 128'(start_cyc), 128'(k + 2));
        check("issue_after_ack_cnt", 128'(start_cnt - s0), 128'(1));
        drain();

        // multiplier never completes: timeout abort
        stuck = 1'b1;
        a0 = abort_cnt;
        push_req(32'd4, 64'd4, 1'b0, 2'd3);
        void'(exp_q.pop_back());
        exp_q.push_back({1'b1, 2'd3, 64'd0});
        n = 0;
        while (abort_cnt == a0 && n < 100) begin
            wait_cycles(1);
            n++;
        end
        check("abort_once", 128'(abort_cnt - a0), 128'(1));
        check("abort_delay", 128'(abort_cyc - start_cyc), 128'(TIMEOUT));
        check("abort_rsp_valid", 128'(rsp_valid), 128'(1'b1));
        check("abort_rsp_err", 128'(rsp_err), 128'(1'b1));
        check("abort_rsp_result", 128'(rsp_result), 128'(0));
        drain();
        stuck = 1'b0;

        // reset mid-operation drops everything
        push_req(32'd7, 64'd7, 1'b0, 2'd1);
        push_req(32'd8, 64'd8, 1'b0, 2'd2);
        wait_cycles(10);
        check("pre_reset_busy", 128'(dbg_state), 128'(BUSY_S));
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_q.delete();
        wait_cycles(2);
        reset = 1'b1;
        s0 = start_cnt;
        k  = rsp_seen;
        wait_cycles(60);
        check("post_reset_no_start", 128'(start_cnt - s0), 128'(0));
        check("post_reset_no_rsp", 128'(rsp_seen - k), 128'(0));
        check("post_reset_empty", 128'(req_ready), 128'(1'b1));
        check("post_reset_idle", 128'(dbg_state), 128'(0));

        // randomized traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            push_req($urandom, {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                     TAG_W'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) wait_cycles(1);
            if ($urandom_range(0, 4) == 0) wait_cycles(40);
        end
        drain();
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        wait_cycles(3);

        check("operand_stability", 128'(stab_err), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_issue_queue.md
Name: mul_issue_queue

Overview:
- Upstream sequencer for the 32x64 shift-add multiplier.
- Buffers operation requests in a small FIFO and drives the multiplier's start/operand/muordi interface with legal timing.
- Detects completion from the multiplier's level-type valid and returns the result with a tag.
- Rejects divide requests (muordi=1) with an error response, because the multiplier never asserts valid for them.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, at least 2).
- TAG_W, 2, width of the request/response tag.
- TIMEOUT, 48, cycles allowed in BUSY before the operation is aborted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept a request.
- req_opera1  in  32  operand 1.
- req_opera2  in  64  operand 2.
- req_muordi  in  1  0 = multiply, 1 = divide (unsupported).
- req_tag  in  TAG_W  request identifier.
- mul_opera1  out  32  to multiplier opera1.
- mul_opera2  out  64  to multiplier opera2.
- mul_muordi  out  1  to multiplier muordi; always 0 when issued.
- mul_start  out  1  one-cycle start pulse.
- mul_abort  out  1  one-cycle pulse to the multiplier's active-high reset.
- mul_result  in  64  multiplier result.
- mul_valid  in  1  multiplier valid (level; stays high until the next start).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  64  captured result.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_err  out  1  1 = divide rejected or timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied and the FSM goes to IDLE.
  - All outputs are 0, except req_ready=1.
  - The timeout counter is 0.
- FIFO:
  - Push when req_valid and req_ready are both high.
  - req_ready = not full.
  - Pop only on leaving IDLE. There is no push-bypass into an empty FIFO.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - Pointers wrap modulo DEPTH.
- Operand registers:
  - mul_opera1, mul_opera2 and the current tag are loaded on pop.
  - They are held stable through START, CLEAR, BUSY and SETTLE, because the multiplier reads operands combinationally during the whole operation.
- FSM states:
  - IDLE:
    - FIFO empty: stay.
    - Head has muordi=1: pop; rsp_result=0, rsp_err=1; go to RESP. No mul_start is issued.
    - Otherwise: pop; go to START.
  - START: mul_start=1 for exactly one cycle; go to CLEAR.
  - CLEAR:
    - Wait for mul_valid=0 (the previous operation's valid drops two edges after start).
    - The timeout counter runs.
    - When mul_valid=0, go to BUSY.
  - BUSY: wait for mul_valid=1, then go to SETTLE.
  - SETTLE:
    - Exactly one cycle: the multiplier applies sign correction on the cycle after valid rises.
    - Capture mul_result into rsp_result; rsp_err=0; go to RESP.
  - RESP:
    - rsp_valid=1, and rsp_result/rsp_tag/rsp_err are held until rsp_ready=1.
    - On the handshake, go to IDLE.
- Timeout:
  - The counter clears on START and increments in CLEAR and BUSY.
  - When it reaches TIMEOUT: mul_abort=1 for one cycle; rsp_result=0, rsp_err=1; go to RESP.
- Latency: a multiply response appears 36 cycles after pop, given 33 multiplier iterations.
- Reset mid-operation: the operation is dropped with no response, and queued requests are lost.
- While in RESP the FIFO still accepts pushes; there is no new issue until the response handshake completes.

Decomposition:
- Package alu_pkg:
  - FSM state enum: IDLE, START, CLEAR, BUSY, SETTLE, RESP.
  - Constants OP_MUL=0 and OP_DIV=1.
  - Constants OPERA1_W=32, OPERA2_W=64, RESULT_W=64.
- One sub-module, op_fifo:
  - Synchronous FIFO, DEPTH x (1+32+64+TAG_W).
  - Provides full/empty flags.
  - Resets asynchronously on active-low reset.

Test Plan:
- Single multiply, opera1=3, opera2=5, tag=1, multiplier model returns 15:
  - exactly one mul_start pulse;
  - rsp_valid with rsp_result=64'h0000_0000_0000_000F, rsp_tag=1, rsp_err=0.
- Signed multiply -7 x 6, model result 64'hFFFF_FFFF_FFFF_FFD6:
  - rsp_result matches;
  - mul_opera1/mul_opera2 stable every cycle from START to SETTLE.
- Divide request (muordi=1, tag=2):
  - no mul_start;
  - rsp_valid two cycles after push, with rsp_err=1, rsp_result=0, rsp_tag=2.
- Push 5 requests back-to-back while the first is executing:
  - req_ready=0 after the 4th is accepted;
  - responses come out in order with tags preserved.
- Hold rsp_ready=0 for 20 cycles after completion:
  - rsp fields stay constant;
  - no new mul_start;
  - after rsp_ready=1 the next request issues the following cycle.
- mul_valid stuck at 0:
  - mul_abort pulses at cycle TIMEOUT=48 after START, then rsp_err=1.
- Separately, reset=0 asserted in BUSY: all outputs go to reset values immediately, and the FIFO is empty.
